// File: rtl/eth_pkg.sv
// Shared Ethernet management types and constants: MDIO arbiter state/owner
// enums, MDIO opcode values and the BMSR register/link-bit location.
package eth_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } tMdio_Arb_State;

    typedef enum logic {
        OWN_HOST = 1'b0,
        OWN_POLL = 1'b1
    } tMdio_Arb_Owner;

    localparam logic       cMDIO_Rd       = 1'b0;
    localparam logic       cMDIO_Wr       = 1'b1;
    localparam logic [4:0] cBMSR_Addr     = 5'd1;
    localparam int         cBMSR_Link_Bit = 2;

    // Round-robin: on a tie the requester that did not own the last slot wins.
    function automatic logic grant_poll(input logic           host_req,
                                        input logic           poll_pend,
                                        input tMdio_Arb_Owner last_grant);
        return poll_pend && (!host_req || (last_grant == OWN_HOST));
    endfunction

endpackage

// File: rtl/eth_mdio_arb_if.sv
// Host request/response, poll status and eth_mdio transaction signals of the
// MDIO arbiter; slave is the arbiter's view, master is the environment's.
interface eth_mdio_arb_if;

    logic        Host_Req;
    logic [4:0]  Host_Phy_Addr;
    logic [4:0]  Host_Reg_Addr;
    logic        Host_Transc_Type;
    logic [15:0] Host_Wr_Dat;
    logic        Host_Ack;
    logic [15:0] Host_Rd_Dat;
    logic        Host_Rd_Valid;
    logic        Host_Err;
    logic        Busy;

    logic        Poll_En;
    logic [15:0] Poll_Dat;
    logic        Link_Up;
    logic        Link_Valid;

    logic [4:0]  MDIO_Phy_Addr;
    logic [4:0]  MDIO_Reg_Addr;
    logic        MDIO_Transc_Type;
    logic [15:0] MDIO_Wr_Dat;
    logic        MDIO_En;
    logic        MDIO_Busy;
    logic        MDIO_Data_Valid;
    logic [15:0] MDIO_Data;

    // Handshake: Host_Req is a level held until the single-cycle Host_Ack;
    // MDIO_En is a one-cycle start, MDIO_Busy brackets the eth_mdio frame and
    // MDIO_Data_Valid is a one-cycle strobe carrying MDIO_Data.
    modport slave (
        input  Host_Req, Host_Phy_Addr, Host_Reg_Addr, Host_Transc_Type, Host_Wr_Dat,
        output Host_Ack, Host_Rd_Dat, Host_Rd_Valid, Host_Err, Busy,
        input  Poll_En,
        output Poll_Dat, Link_Up, Link_Valid,
        output MDIO_Phy_Addr, MDIO_Reg_Addr, MDIO_Transc_Type, MDIO_Wr_Dat, MDIO_En,
        input  MDIO_Busy, MDIO_Data_Valid, MDIO_Data
    );

    modport master (
        output Host_Req, Host_Phy_Addr, Host_Reg_Addr, Host_Transc_Type, Host_Wr_Dat,
        input  Host_Ack, Host_Rd_Dat, Host_Rd_Valid, Host_Err, Busy,
        output Poll_En,
        input  Poll_Dat, Link_Up, Link_Valid,
        input  MDIO_Phy_Addr, MDIO_Reg_Addr, MDIO_Transc_Type, MDIO_Wr_Dat, MDIO_En,
        output MDIO_Busy, MDIO_Data_Valid, MDIO_Data
    );

endinterface

// File: rtl/eth_mdio_poll_tmr.sv
// Periodic poll request generator: free-running period counter while enabled,
// with a sticky pending flag cleared by the arbiter's poll grant.
module eth_mdio_poll_tmr #(
    parameter int pPoll_Period = 1000
) (
    input  logic Clk,
    input  logic Rstn,
    input  logic Poll_En,
    input  logic Poll_Ack,
    output logic Poll_Pend
);

    localparam int               cCntW    = $clog2(pPoll_Period);
    localparam logic [cCntW-1:0] cCntLast = cCntW'(pPoll_Period - 1);

    logic [cCntW-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic             term_cnt;

    always_comb begin
        cnt_d    = cnt_q;
        pend_d   = pend_q;
        term_cnt = 1'b0;
        if (!Poll_En) begin
            cnt_d  = '0;
            pend_d = 1'b0;
        end else begin
            if (cnt_q == cCntLast) begin
                cnt_d    = '0;
                term_cnt = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            // A terminal count landing on the grant cycle re-arms the request.
            if (term_cnt) begin
                pend_d = 1'b1;
            end else if (Poll_Ack) begin
                pend_d = 1'b0;
            end
        end
    end

    always_ff @(posedge Clk or negedge Rstn) begin
        if (!Rstn) begin
            cnt_q  <= '0;
            pend_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
        end
    end

    assign Poll_Pend = pend_q;

endmodule

// File: rtl/eth_mdio_arb.sv
// MDIO slot arbiter: shares one eth_mdio transaction port between the host
// register path and the periodic BMSR poller, with timeout and data return.
module eth_mdio_arb
    import eth_pkg::*;
#(
    parameter logic [4:0] pPhy_Addr    = 5'd1,
    parameter logic [4:0] pPoll_Reg    = cBMSR_Addr,
    parameter int         pPoll_Period = 1000,
    parameter int         pTimeout     = 256
) (
    input  logic           Clk,
    input  logic           Rstn,
    eth_mdio_arb_if.slave  bus,
    output tMdio_Arb_State dbg_state
);

    localparam int              cTmoW    = $clog2(pTimeout);
    localparam logic [cTmoW-1:0] cTmoLast = cTmoW'(pTimeout - 1);

    tMdio_Arb_State   state_q, state_d;
    tMdio_Arb_Owner   owner_q, owner_d;
    tMdio_Arb_Owner   last_grant_q, last_grant_d;
    logic [cTmoW-1:0] tmo_q, tmo_d;

    logic [4:0]  mdio_phy_q, mdio_phy_d;
    logic [4:0]  mdio_reg_q, mdio_reg_d;
    logic        mdio_type_q, mdio_type_d;
    logic [15:0] mdio_wr_dat_q, mdio_wr_dat_d;
    logic        mdio_en_q, mdio_en_d;

    logic        host_ack_q, host_ack_d;
    logic [15:0] host_rd_dat_q, host_rd_dat_d;
    logic        host_rd_valid_q, host_rd_valid_d;
    logic        host_err_q, host_err_d;
    logic        busy_q, busy_d;

    logic [15:0] poll_dat_q, poll_dat_d;
    logic        link_up_q, link_up_d;
    logic        link_valid_q, link_valid_d;

    logic poll_pend;
    logic poll_ack;
    logic tmo_hit;

    eth_mdio_poll_tmr #(
        .pPoll_Period (pPoll_Period)
    ) u_poll_tmr (
        .Clk       (Clk),
        .Rstn      (Rstn),
        .Poll_En   (bus.Poll_En),
        .Poll_Ack  (poll_ack),
        .Poll_Pend (poll_pend)
    );

    assign tmo_hit = (tmo_q == cTmoLast);

    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        last_grant_d    = last_grant_q;
        tmo_d           = tmo_q;
        mdio_phy_d      = mdio_phy_q;
        mdio_reg_d      = mdio_reg_q;
        mdio_type_d     = mdio_type_q;
        mdio_wr_dat_d   = mdio_wr_dat_q;
        mdio_en_d       = 1'b0;
        host_ack_d      = 1'b0;
        host_rd_dat_d   = host_rd_dat_q;
        host_rd_valid_d = 1'b0;
        host_err_d      = 1'b0;
        poll_dat_d      = poll_dat_q;
        link_up_d       = link_up_q;
        link_valid_d    = link_valid_q;
        poll_ack        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.Host_Req || poll_pend) begin
                    if (grant_poll(bus.Host_Req, poll_pend, last_grant_q)) begin
                        owner_d       = OWN_POLL;
                        mdio_phy_d    = pPhy_Addr;
                        mdio_reg_d    = pPoll_Reg;
                        mdio_type_d   = cMDIO_Rd;
                        mdio_wr_dat_d = 16'h0000;
                        poll_ack      = 1'b1;
                    end else begin
                        owner_d       = OWN_HOST;
                        mdio_phy_d    = bus.Host_Phy_Addr;
                        mdio_reg_d    = bus.Host_Reg_Addr;
                        mdio_type_d   = bus.Host_Transc_Type;
                        mdio_wr_dat_d = bus.Host_Wr_Dat;
                        host_ack_d    = 1'b1;
                    end
                    last_grant_d = owner_d;
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                mdio_en_d = 1'b1;
                tmo_d     = '0;
                state_d   = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (bus.MDIO_Busy) begin
                    tmo_d   = '0;
                    state_d = ST_WAIT_DONE;
                end else if (tmo_hit) begin
                    host_err_d = (owner_q == OWN_HOST);
                    state_d    = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if ((mdio_type_q == cMDIO_Rd) && bus.MDIO_Data_Valid) begin
                    if (owner_q == OWN_HOST) begin
                        host_rd_dat_d   = bus.MDIO_Data;
                        host_rd_valid_d = 1'b1;
                    end else if (bus.Poll_En) begin
                        poll_dat_d   = bus.MDIO_Data;
                        link_up_d    = bus.MDIO_Data[cBMSR_Link_Bit];
                        link_valid_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end else if ((mdio_type_q == cMDIO_Wr) && !bus.MDIO_Busy) begin
                    state_d = ST_IDLE;
                end else if (tmo_hit) begin
                    // Poll aborts are silent: the last good status is kept.
                    host_err_d = (owner_q == OWN_HOST);
                    state_d    = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (!bus.Poll_En) begin
            link_valid_d = 1'b0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge Clk or negedge Rstn) begin
        if (!Rstn) begin
            state_q         <= ST_IDLE;
            owner_q         <= OWN_HOST;
            last_grant_q    <= OWN_POLL;
            tmo_q           <= '0;
            mdio_phy_q      <= '0;
            mdio_reg_q      <= '0;
            mdio_type_q     <= 1'b0;
            mdio_wr_dat_q   <= '0;
            mdio_en_q       <= 1'b0;
            host_ack_q      <= 1'b0;
            host_rd_dat_q   <= '0;
            host_rd_valid_q <= 1'b0;
            host_err_q      <= 1'b0;
            busy_q          <= 1'b0;
            poll_dat_q      <= '0;
            link_up_q       <= 1'b0;
            link_valid_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            owner_q         <= owner_d;
            last_grant_q    <= last_grant_d;
            tmo_q           <= tmo_d;
            mdio_phy_q      <= mdio_phy_d;
            mdio_reg_q      <= mdio_reg_d;
            mdio_type_q     <= mdio_type_d;
            mdio_wr_dat_q   <= mdio_wr_dat_d;
            mdio_en_q       <= mdio_en_d;
            host_ack_q      <= host_ack_d;
            host_rd_dat_q   <= host_rd_dat_d;
            host_rd_valid_q <= host_rd_valid_d;
            host_err_q      <= host_err_d;
            busy_q          <= busy_d;
            poll_dat_q      <= poll_dat_d;
            link_up_q       <= link_up_d;
            link_valid_q    <= link_valid_d;
        end
    end

    assign bus.Host_Ack         = host_ack_q;
    assign bus.Host_Rd_Dat      = host_rd_dat_q;
    assign bus.Host_Rd_Valid    = host_rd_valid_q;
    assign bus.Host_Err         = host_err_q;
    assign bus.Busy             = busy_q;
    assign bus.Poll_Dat         = poll_dat_q;
    assign bus.Link_Up          = link_up_q;
    assign bus.Link_Valid       = link_valid_q;
    assign bus.MDIO_Phy_Addr    = mdio_phy_q;
    assign bus.MDIO_Reg_Addr    = mdio_reg_q;
    assign bus.MDIO_Transc_Type = mdio_type_q;
    assign bus.MDIO_Wr_Dat      = mdio_wr_dat_q;
    assign bus.MDIO_En          = mdio_en_q;
    assign dbg_state            = state_q;

endmodule

// File: tb/tb_eth_mdio_arb.sv
// Bench for eth_mdio_arb: directed host/poll traffic against a small eth_mdio
// model, with queued expectations checked by a free-running monitor.
module tb_eth_mdio_arb;
  import eth_pkg::*;

  localparam int cPeriod = 100;
  localparam int cTmo    = 64;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  eth_mdio_arb_if bus ();
  tMdio_Arb_State dbg_state;

  eth_mdio_arb #(
    .pPhy_Addr    (5'd1),
    .pPoll_Reg    (5'd1),
    .pPoll_Period (cPeriod),
    .pTimeout     (cTmo)
  ) dut (
    .Clk       (clk),
    .Rstn      (rstn),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  logic [26:0] exp_issue_q[$];
  logic [15:0] exp_rd_q[$];
  logic [4:0]  exp_err_q[$];
  logic [4:0]  exp_ack_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_evt(input string name, input logic [31:0] act);
    tests_run++;
    tests_failed++;
    $display("FAIL %s: got %0h with nothing expected", name, act);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // ---------------- scoreboard monitor ----------------
  logic [26:0] mon_issue;
  logic [26:0] mon_exp_issue;
  logic [15:0] mon_exp_rd;
  logic [4:0]  mon_exp_reg;
  assign mon_issue = {bus.MDIO_Phy_Addr, bus.MDIO_Reg_Addr, bus.MDIO_Transc_Type, bus.MDIO_Wr_Dat};

  always @(negedge clk) begin
    if (bus.MDIO_En) begin
      if (exp_issue_q.size() == 0) fail_evt("mdio_issue_unexpected", 32'(mon_issue));
      else begin
        mon_exp_issue = exp_issue_q.pop_front();
        check("mdio_issue", 32'(mon_issue), 32'(mon_exp_issue));
      end
    end
    if (bus.Host_Ack) begin
      if (exp_ack_q.size() == 0) fail_evt("host_ack_unexpected", 32'(bus.MDIO_Reg_Addr));
      else begin
        mon_exp_reg = exp_ack_q.pop_front();
        check("host_ack_reg", 32'(bus.MDIO_Reg_Addr), 32'(mon_exp_reg));
      end
    end
    if (bus.Host_Rd_Valid) begin
      if (exp_rd_q.size() == 0) fail_evt("host_rd_unexpected", 32'(bus.Host_Rd_Dat));
      else begin
        mon_exp_rd = exp_rd_q.pop_front();
        check("host_rd_dat", 32'(bus.Host_Rd_Dat), 32'(mon_exp_rd));
      end
    end
    if (bus.Host_Err) begin
      if (exp_err_q.size() == 0) fail_evt("host_err_unexpected", 32'(bus.MDIO_Reg_Addr));
      else begin
        mon_exp_reg = exp_err_q.pop_front();
        check("host_err_reg", 32'(bus.MDIO_Reg_Addr), 32'(mon_exp_reg));
      end
    end
  end

  // ---------------- eth_mdio model ----------------
  logic [15:0] model_bmsr = 16'h0000;
  logic [15:0] model_rd = 16'h0000;
  int          model_busy = 5;
  bit          model_never_busy = 1'b0;
  int          model_n;
  logic        model_is_rd;
  logic [15:0] model_d;

  initial begin
    bus.MDIO_Busy = 1'b0;
    bus.MDIO_Data_Valid = 1'b0;
    bus.MDIO_Data = 16'h0000;
    forever begin
      @(negedge clk);
      if (bus.MDIO_En && !model_never_busy) begin
        model_n = model_busy;
        model_is_rd = (bus.MDIO_Transc_Type == cMDIO_Rd);
        model_d = (bus.MDIO_Reg_Addr == cBMSR_Addr) ? model_bmsr : model_rd;
        bus.MDIO_Busy = 1'b1;
        repeat (model_n) @(negedge clk);
        if (model_is_rd) begin
          bus.MDIO_Data = model_d;
          bus.MDIO_Data_Valid = 1'b1;
          @(negedge clk);
          bus.MDIO_Data_Valid = 1'b0;
        end
        bus.MDIO_Busy = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic host_start(input logic [4:0] phy, input logic [4:0] rg, input logic typ,
                            input logic [15:0] wd);
    bus.Host_Phy_Addr = phy;
    bus.Host_Reg_Addr = rg;
    bus.Host_Transc_Type = typ;
    bus.Host_Wr_Dat = wd;
    bus.Host_Req = 1'b1;
    exp_issue_q.push_back({phy, rg, typ, wd});
    exp_ack_q.push_back(rg);
  endtask

  task automatic wait_ack(output int k);
    k = 0;
    while (k < 400) begin
      tick();
      k++;
      if (bus.Host_Ack) break;
    end
    if (!bus.Host_Ack) fail_evt("host_ack_timeout", 32'(k));
    bus.Host_Req = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (bus.Busy && k < 400) begin
      tick();
      k++;
    end
    if (bus.Busy) fail_evt("idle_timeout", 32'(k));
  endtask

  task automatic wait_mdio_en(output int k);
    k = 0;
    while (k < 1000) begin
      tick();
      k++;
      if (bus.MDIO_En) break;
    end
    if (!bus.MDIO_En) fail_evt("mdio_en_timeout", 32'(k));
  endtask

  task automatic poll_expect();
    exp_issue_q.push_back({5'd1, 5'd1, cMDIO_Rd, 16'h0000});
  endtask

  task automatic host_xact(input string name, input logic [4:0] rg, input logic typ,
                           input logic [15:0] wd, input logic [15:0] rd_exp);
    int k;
    host_start(5'd1, rg, typ, wd);
    if (typ == cMDIO_Rd) exp_rd_q.push_back(rd_exp);
    wait_ack(k);
    check({name, "_ack_latency"}, 32'(k), 32'd1);
    tick();
    check({name, "_en_after_ack"}, 32'(bus.MDIO_En), 32'd1);
    wait_idle();
  endtask

  // ---------------- directed sequence ----------------
  int  k;
  int  cyc0;
  bit  seen_busy;
  logic prev_busy;

  initial begin
    bus.Host_Req = 1'b0;
    bus.Host_Phy_Addr = 5'd0;
    bus.Host_Reg_Addr = 5'd0;
    bus.Host_Transc_Type = 1'b0;
    bus.Host_Wr_Dat = 16'h0000;
    bus.Poll_En = 1'b0;

    repeat (3) tick();
    check("rst_busy", 32'(bus.Busy), 32'd0);
    check("rst_mdio_en", 32'(bus.MDIO_En), 32'd0);
    check("rst_link_valid", 32'(bus.Link_Valid), 32'd0);
    check("rst_poll_dat", 32'(bus.Poll_Dat), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rstn = 1'b1;
    repeat (2) tick();

    // 1: host read of reg 2
    model_rd = 16'h0022;
    model_busy = 5;
    host_xact("t1", 5'd2, cMDIO_Rd, 16'h0000, 16'h0022);
    check("t1_rd_dat_hold", 32'(bus.Host_Rd_Dat), 32'h0022);

    // 2: host write, Busy must drop on the edge that sees MDIO_Busy low
    model_busy = 40;
    host_start(5'd1, 5'd0, cMDIO_Wr, 16'h1200);
    wait_ack(k);
    seen_busy = 1'b0;
    prev_busy = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (bus.MDIO_Busy) seen_busy = 1'b1;
      else if (seen_busy) break;
      prev_busy = bus.Busy;
    end
    check("t2_busy_before_fall", 32'(prev_busy), 32'd1);
    check("t2_busy_after_fall", 32'(bus.Busy), 32'd0);
    check("t2_wr_dat_hold", 32'(bus.MDIO_Wr_Dat), 32'h1200);

    // 5: timeout with no MDIO_Busy, then a normal transaction
    model_busy = 5;
    model_never_busy = 1'b1;
    host_start(5'd1, 5'd3, cMDIO_Rd, 16'h0000);
    exp_err_q.push_back(5'd3);
    wait_ack(k);
    k = 0;
    while (k < 200) begin
      tick();
      k++;
      if (bus.Host_Err) break;
    end
    // Ack is seen in ISSUE; WAIT_BUSY starts one edge later and lasts cTmo cycles.
    check("t5_err_latency", 32'(k), 32'(cTmo + 1));
    check("t5_busy_at_err", 32'(bus.Busy), 32'd0);
    model_never_busy = 1'b0;
    model_rd = 16'hBEEF;
    host_xact("t5b", 5'd4, cMDIO_Rd, 16'h0000, 16'hBEEF);

    // 3: polling; pend at count 100, grant one edge later, MDIO_En one after
    model_bmsr = 16'h782D;
    poll_expect();
    bus.Poll_En = 1'b1;
    wait_mdio_en(k);
    check("t3_first_poll_cycle", 32'(k), 32'(cPeriod + 2));
    wait_idle();
    check("t3_poll_dat", 32'(bus.Poll_Dat), 32'h782D);
    check("t3_link_up", 32'(bus.Link_Up), 32'd1);
    check("t3_link_valid", 32'(bus.Link_Valid), 32'd1);
    model_bmsr = 16'h7809;
    poll_expect();
    wait_mdio_en(k);
    wait_idle();
    check("t3b_poll_dat", 32'(bus.Poll_Dat), 32'h7809);
    check("t3b_link_up", 32'(bus.Link_Up), 32'd0);
    check("t3b_link_valid", 32'(bus.Link_Valid), 32'd1);

    // 6: reset during a poll's WAIT_DONE
    model_bmsr = 16'h782D;
    model_busy = 20;
    poll_expect();
    wait_mdio_en(k);
    repeat (5) tick();
    check("t6_state_pre", 32'(dbg_state), 32'(ST_WAIT_DONE));
    rstn = 1'b0;
    #1;
    check("t6_busy", 32'(bus.Busy), 32'd0);
    check("t6_link_valid", 32'(bus.Link_Valid), 32'd0);
    check("t6_poll_dat", 32'(bus.Poll_Dat), 32'd0);
    check("t6_mdio_reg", 32'(bus.MDIO_Reg_Addr), 32'd0);
    check("t6_mdio_phy", 32'(bus.MDIO_Phy_Addr), 32'd0);
    check("t6_state", 32'(dbg_state), 32'(ST_IDLE));
    repeat (2) tick();
    rstn = 1'b1;
    model_busy = 5;
    poll_expect();
    wait_mdio_en(k);
    check("t6_poll_after_rst", 32'(k), 32'(cPeriod + 2));
    wait_idle();
    bus.Poll_En = 1'b0;
    tick();
    check("t6_poll_en_low_clears", 32'(bus.Link_Valid), 32'd0);

    // 4: host/poll tie from reset, then a tie after a host grant
    rstn = 1'b0;
    bus.Poll_En = 1'b1;
    model_busy = 5;
    model_rd = 16'h1111;
    repeat (2) tick();
    rstn = 1'b1;
    cyc0 = cyc;
    repeat (cPeriod) tick();
    host_start(5'd1, 5'd5, cMDIO_Rd, 16'h0000);
    exp_rd_q.push_back(16'h1111);
    poll_expect();
    wait_ack(k);
    check("t4_host_first", 32'(k), 32'd1);
    wait_idle();
    wait_mdio_en(k);
    check("t4_poll_second_reg", 32'(bus.MDIO_Reg_Addr), 32'd1);
    wait_idle();

    while (cyc - cyc0 < 170) tick();
    model_busy = 50;
    model_rd = 16'h2222;
    host_start(5'd1, 5'd6, cMDIO_Rd, 16'h0000);
    exp_rd_q.push_back(16'h2222);
    poll_expect();
    wait_ack(k);
    check("t4b_host1_ack", 32'(k), 32'd1);
    repeat (3) tick();
    model_busy = 5;
    model_rd = 16'h3333;
    host_start(5'd1, 5'd7, cMDIO_Rd, 16'h0000);
    exp_rd_q.push_back(16'h3333);
    wait_ack(k);
    wait_idle();
    bus.Poll_En = 1'b0;

    repeat (10) tick();
    check("issue_q_empty", 32'(exp_issue_q.size()), 32'd0);
    check("rd_q_empty", 32'(exp_rd_q.size()), 32'd0);
    check("err_q_empty", 32'(exp_err_q.size()), 32'd0);
    check("ack_q_empty", 32'(exp_ack_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d cycles", cyc);
    $fatal(1, "watchdog");
  end

endmodule
